// File: rtl/skew_feeder.sv
// skew_feeder: sends skewed read strobes to LANES row buffers and presents the
// returned words, zero-padded outside the diagonal, to the west edge of a
// systolic array. One tile of VECLEN words per lane is sequenced per start.
module skew_feeder #(
  parameter int WORDLEN = 8,
  parameter int LANES   = 4,
  parameter int VECLEN  = 16,
  parameter int CNTBITS = 5
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       clr,
  input  logic                       en,
  output logic [LANES-1:0]           rd_en,
  input  logic [LANES*WORDLEN-1:0]   buf_dout,
  output logic [LANES*WORDLEN-1:0]   arr_dat,
  output logic [LANES-1:0]           arr_vld,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Wavefront position at which the last lane issues its final strobe.
  localparam logic [CNTBITS-1:0] LAST = CNTBITS'(VECLEN + LANES - 2);

  state_t             state, state_next;
  logic [CNTBITS-1:0] cnt, cnt_next;
  logic               feeding;

  // State and skew counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: clr dominates start; en=0 freezes the wavefront in FEED.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (!clr && start) begin
          state_next = FEED;
          cnt_next   = '0;
        end
      end
      FEED: begin
        if (clr) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (en) begin
          if (cnt == LAST) begin
            state_next = DRAIN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNTBITS'(1);
          end
        end
      end
      DRAIN: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign feeding = (state == FEED);
  assign busy    = (state != IDLE);
  // The single DRAIN cycle lines up with the last word on the last lane.
  assign done    = (state == DRAIN);

  // Per-lane strobe window [gi, gi+VECLEN) and the zero-padding output mux.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [CNTBITS-1:0] HI = CNTBITS'(gi + VECLEN);
    logic in_window;
    if (gi == 0) begin : g_first
      assign in_window = (cnt < HI);
    end else begin : g_rest
      assign in_window = (cnt >= CNTBITS'(gi)) && (cnt < HI);
    end
    assign rd_en[gi] = feeding & en & in_window;
    assign arr_dat[gi*WORDLEN +: WORDLEN] =
      arr_vld[gi] ? buf_dout[gi*WORDLEN +: WORDLEN] : '0;
  end

  // Buffers present data one cycle after the strobe, so valid trails rd_en by one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      arr_vld <= '0;
    end else begin
      arr_vld <= rd_en;
    end
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Bench for skew_feeder: behavioural buffers, a token-passing wavefront model
// checked every cycle, directed literal scenarios and a randomized phase.
module tb_skew_feeder;
  localparam int WL = 8;
  localparam int NL = 4;
  localparam int VL = 16;
  localparam int CB = 5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic clr = 1'b0;
  logic en = 1'b1;
  logic [NL-1:0]    rd_en, arr_vld;
  logic [NL*WL-1:0] buf_dout = '0;
  logic [NL*WL-1:0] arr_dat;
  logic busy, done;

  // Second, minimal instance for the one-lane / one-word corner case.
  logic       start1 = 1'b0;
  logic [0:0] rd1, vld1;
  logic [7:0] buf1 = '0;
  logic [7:0] dat1;
  logic       busy1, done1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  skew_feeder #(.WORDLEN(WL), .LANES(NL), .VECLEN(VL), .CNTBITS(CB)) dut (
    .clk(clk), .rstn(rstn), .start(start), .clr(clr), .en(en),
    .rd_en(rd_en), .buf_dout(buf_dout), .arr_dat(arr_dat),
    .arr_vld(arr_vld), .busy(busy), .done(done)
  );

  skew_feeder #(.WORDLEN(8), .LANES(1), .VECLEN(1), .CNTBITS(2)) u_one (
    .clk(clk), .rstn(rstn), .start(start1), .clr(clr), .en(en),
    .rd_en(rd1), .buf_dout(buf1), .arr_dat(dat1),
    .arr_vld(vld1), .busy(busy1), .done(done1)
  );

  // Buffer contents: first tile holds i*16+k per lane, the rest is random.
  logic [WL-1:0] mem [NL][256];
  int bptr [NL] = '{default: 0};

  initial begin
    for (int i = 0; i < NL; i++)
      for (int j = 0; j < 256; j++)
        mem[i][j] = (j < 16) ? 8'(i * 16 + j) : 8'($urandom);
  end

  // Behavioural buffers: output word registered on each read strobe.
  always @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (rd_en[i]) begin
        buf_dout[i*WL +: WL] <= mem[i][bptr[i]];
        bptr[i] <= (bptr[i] + 1) % 256;
      end
    end
    if (rd1[0]) buf1 <= 8'h5A;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, exp, $time);
  endtask

  // Model: lane 0 reads for its first VL active steps; every other lane reads
  // in an active step exactly when its upstream neighbour read in the previous one.
  bit            m_feed = 1'b0;
  bit            m_drain = 1'b0;
  int            issued [NL] = '{default: 0};
  logic [NL-1:0] prev = '0;
  logic [NL-1:0] m_vld = '0;
  logic [WL-1:0] m_dat [NL] = '{default: '0};
  int            mptr [NL] = '{default: 0};

  function automatic logic [NL-1:0] exp_rd_f();
    logic [NL-1:0] r;
    r = '0;
    if (m_feed && en) begin
      for (int i = 0; i < NL; i++) begin
        if (i == 0) r[i] = (issued[0] < VL);
        else        r[i] = prev[i-1];
      end
    end
    return r;
  endfunction

  task automatic model_clear_tile();
    prev = '0;
    for (int i = 0; i < NL; i++) issued[i] = 0;
  endtask

  task automatic model_reset();
    m_feed = 1'b0;
    m_drain = 1'b0;
    m_vld = '0;
    model_clear_tile();
  endtask

  // Model advance at each edge, full output compare mid-cycle.
  initial begin
    forever begin
      @(posedge clk);
      if (!rstn) begin
        model_reset();
      end else begin : upd
        logic [NL-1:0] r;
        bit last;
        r = exp_rd_f();
        last = m_feed && en && r[NL-1] && (issued[NL-1] == VL - 1);
        m_vld = r;
        for (int i = 0; i < NL; i++) begin
          if (r[i]) begin
            m_dat[i] = mem[i][mptr[i]];
            mptr[i] = (mptr[i] + 1) % 256;
          end
        end
        if (clr) begin
          m_feed = 1'b0;
          m_drain = 1'b0;
          model_clear_tile();
        end else if (m_drain) begin
          m_drain = 1'b0;
        end else if (m_feed) begin
          if (en) begin
            for (int i = 0; i < NL; i++) issued[i] += int'(r[i]);
            prev = r;
            if (last) begin
              m_feed = 1'b0;
              m_drain = 1'b1;
            end
          end
        end else if (start) begin
          m_feed = 1'b1;
          model_clear_tile();
        end
      end
      @(negedge clk);
      if (!rstn) model_reset();
      begin : cmp
        logic [NL*WL-1:0] d;
        for (int i = 0; i < NL; i++) d[i*WL +: WL] = m_vld[i] ? m_dat[i] : '0;
        chk("rd_en", 64'(rd_en), 64'(exp_rd_f()));
        chk("arr_vld", 64'(arr_vld), 64'(m_vld));
        chk("arr_dat", 64'(arr_dat), 64'(d));
        chk("busy", 64'(busy), 64'(m_feed | m_drain));
        chk("done", 64'(done), 64'(m_drain));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One tile whose start is sampled at edge 0; cycle c lies between edges c-1 and c.
  task automatic run_plan(input int en_lo, input int en_hi, input int clr_cyc,
                          input int rs_cyc, input int done_cyc, input bit chk_data);
    int cnt_rd [NL];
    logic [NL-1:0] mr;
    bit nominal;
    nominal = (en_lo == 0) && (clr_cyc <= 0);
    for (int i = 0; i < NL; i++) cnt_rd[i] = 0;
    tick();
    start = 1'b1; en = 1'b1; clr = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      tick();
      start = (c == rs_cyc);
      en = !(c >= en_lo && c <= en_hi);
      clr = (c == clr_cyc);
      #1;
      mr = exp_rd_f();
      for (int i = 0; i < NL; i++) cnt_rd[i] += int'(rd_en[i]);
      chk("plan_done", 64'(done), 64'(c == done_cyc));
      chk("model_done", 64'(m_drain), 64'(c == done_cyc));
      if (c >= en_lo && c <= en_hi) chk("stall_rd", 64'(rd_en), 64'(0));
      if (c >= en_lo + 1 && c <= en_hi + 1) chk("stall_vld", 64'(arr_vld), 64'(0));
      if (clr_cyc > 0) begin
        if (c > clr_cyc) begin
          chk("clr_rd", 64'(rd_en), 64'(0));
          chk("clr_busy", 64'(busy), 64'(0));
        end
        if (c > clr_cyc + 1) chk("clr_vld", 64'(arr_vld), 64'(0));
      end else begin
        chk("plan_busy", 64'(busy), 64'(c >= 1 && c <= done_cyc));
      end
      if (nominal) begin
        chk("rd0_window", 64'(rd_en[0]), 64'(c >= 1 && c <= 16));
        chk("rd3_window", 64'(rd_en[3]), 64'(c >= 4 && c <= 19));
        chk("model_rd3", 64'(mr[3]), 64'(c >= 4 && c <= 19));
        for (int i = 0; i < NL; i++)
          chk("vld_window", 64'(arr_vld[i]), 64'(c >= 2 + i && c <= 17 + i));
        if (chk_data)
          chk("lane3_word", 64'(arr_dat[3*WL +: WL]), 64'((c >= 5 && c <= 20) ? c + 43 : 0));
      end
    end
    clr = 1'b0; start = 1'b0; en = 1'b1;
    if (clr_cyc <= 0)
      for (int i = 0; i < NL; i++) chk("strobes_per_lane", 64'(cnt_rd[i]), 64'(VL));
  endtask

  // Start a tile and wait (bounded) for its done pulse.
  task automatic start_and_wait(input string name);
    bit seen;
    seen = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      #1;
      if (done) seen = 1'b1;
      tick();
    end
    chk(name, 64'(seen), 64'(1));
    repeat (2) tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_rd", 64'(rd_en), 64'(0));
    chk("reset_vld", 64'(arr_vld), 64'(0));
    chk("reset_dat", 64'(arr_dat), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    rstn = 1'b1;
    repeat (2) tick();

    run_plan(0, -1, 0, 0, 20, 1'b1);   // nominal tile, literal data
    run_plan(6, 8, 0, 0, 23, 1'b0);    // en stall in cycles 6..8
    run_plan(0, -1, 10, 0, -1, 1'b0);  // clr mid-FEED
    start_and_wait("restart_after_clr");
    run_plan(0, -1, 0, 5, 20, 1'b0);   // start re-pulsed while busy

    // Asynchronous reset in the middle of cycle 12.
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 12; c++) tick();
    chk("pre_reset_busy", 64'(busy), 64'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rd", 64'(rd_en), 64'(0));
    chk("async_vld", 64'(arr_vld), 64'(0));
    chk("async_dat", 64'(arr_dat), 64'(0));
    chk("async_busy", 64'(busy), 64'(0));
    chk("async_done", 64'(done), 64'(0));
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    chk("post_reset_idle", 64'(busy), 64'(0));
    start_and_wait("tile_after_reset");

    // One lane, one word.
    tick();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    #1;
    chk("one_c1_rd", 64'(rd1), 64'(1));
    chk("one_c1_vld", 64'(vld1), 64'(0));
    chk("one_c1_busy", 64'(busy1), 64'(1));
    chk("one_c1_done", 64'(done1), 64'(0));
    tick();
    chk("one_c2_rd", 64'(rd1), 64'(0));
    chk("one_c2_vld", 64'(vld1), 64'(1));
    chk("one_c2_done", 64'(done1), 64'(1));
    chk("one_c2_dat", 64'(dat1), 64'(8'h5A));
    tick();
    chk("one_c3_busy", 64'(busy1), 64'(0));
    chk("one_c3_done", 64'(done1), 64'(0));
    chk("one_c3_vld", 64'(vld1), 64'(0));

    // Randomized traffic, checked every cycle by the model.
    for (int k = 0; k < 3000; k++) begin
      tick();
      start = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 149) == 0);
    end
    start = 1'b0; clr = 1'b0; en = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/skew_feeder.md
Name: skew_feeder

Overview:
- Stage directly downstream of the per-lane read buffers (RBUF, one per systolic row). It issues `read` pulses to LANES buffers in a diagonal (skewed) pattern, so lane i lags lane i-1 by one cycle.
- It presents the returned words to the west edge of the systolic array, with per-lane valid and zero padding.
- It sequences exactly one tile of VECLEN words per lane per `start`, then pulses `done`.

Parameters:
- WORDLEN, 8, bits per data word; matches the buffer word width.
- LANES, 4, number of buffers/array rows fed.
- VECLEN, 16, words read from each lane per tile.
- CNTBITS, 5, skew counter width; must satisfy 2^CNTBITS > VECLEN+LANES-1.

Ports:
- clk  input  1  single clock.
- rstn  input  1  asynchronous, active-low reset.
- start  input  1  begin one tile; sampled only in IDLE.
- clr  input  1  synchronous abort; returns to IDLE.
- en  input  1  advance enable; low stalls the wavefront.
- rd_en  output  LANES  per-lane read strobe to each buffer's `read`.
- buf_dout  input  LANES*WORDLEN  buffer outputs; lane i at bits [i*WORDLEN +: WORDLEN].
- arr_dat  output  LANES*WORDLEN  array edge data; same lane packing as buf_dout.
- arr_vld  output  LANES  per-lane data valid.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse marking the final word of the tile.

Behaviour:
- Reset: rstn low asynchronously forces state=IDLE and cnt=0. All outputs read 0: rd_en, arr_vld, arr_dat, busy, done. Applies mid-tile too; no recovery of partial tile.
- States: IDLE, FEED, DRAIN.
  - IDLE: start=1 at an edge -> FEED with cnt=0. Otherwise stay in IDLE.
  - FEED, at each edge with en=1:
    - if cnt == VECLEN+LANES-2 -> DRAIN;
    - else cnt <= cnt+1.
    - With en=0, cnt and state hold.
  - DRAIN: unconditionally -> IDLE after one cycle.
- Read issue is combinational from registered cnt/state: rd_en[i] = (state==FEED) & en & (cnt >= i) & (cnt < i+VECLEN).
  - Each lane therefore receives exactly VECLEN strobes per tile.
  - Strobes on lane i are contiguous apart from en stalls.
- Buffer latency: the buffer registers its output on read, so valid data appears one cycle after the strobe.
  - arr_vld[i] is a register: arr_vld[i] <= rd_en[i] each edge.
- arr_dat lane i = buf_dout lane i when arr_vld[i], else 0. This mux is combinational from registered signals, giving the zero padding the array requires outside the diagonal.
- Stall: en=0 zeroes all rd_en that cycle, so all lanes bubble together and skew alignment is preserved. The array consumes the same en.
- done: asserted exactly in the DRAIN cycle, which coincides with the last arr_vld[LANES-1]. busy covers FEED and DRAIN.
- start while busy: ignored, no queueing.
- start and clr in the same IDLE cycle: clr wins, stay IDLE.
- clr in FEED or DRAIN:
  - next edge: state=IDLE, cnt=0;
  - rd_en is 0 from that edge on; arr_vld clears one edge later;
  - done is not asserted for the aborted tile.
- No empty check: upstream guarantees at least VECLEN words per buffer before start. The buffer head pointers are not rewound on clr.
- Total tile latency with no stalls: start edge to done = VECLEN+LANES cycles.

Test Plan:
- LANES=4, VECLEN=16, en=1, buffers preloaded with lane i words i*16+k. start pulse sampled at edge 0 ->
  - rd_en[0] high cycles 1..16 and rd_en[3] high cycles 4..19;
  - arr_vld[i] high cycles 2+i..17+i;
  - arr_dat lane 3 = 48..63 in order, 0 elsewhere;
  - done high only at cycle 20; busy high cycles 1..20.
- Same setup, en=0 for cycles 6..8 -> every rd_en is 0 in cycles 6..8, all arr_vld are 0 in cycles 7..9, and done moves to cycle 23 with no lost or duplicated words.
- clr asserted at cycle 10 mid-FEED ->
  - rd_en all 0 from cycle 11, arr_vld all 0 from cycle 12;
  - busy low from cycle 11; no done pulse;
  - a fresh start is then accepted.
- start re-pulsed at cycle 5 during FEED -> ignored; exactly 16 strobes per lane and a single done at cycle 20.
- rstn driven low asynchronously mid-cycle at cycle 12 -> all outputs 0 immediately (before the next clk edge); after release, state is IDLE and start begins a clean tile.
- Edge case LANES=1, VECLEN=1 -> rd_en[0] high cycle 1, arr_vld[0] high cycle 2, done at cycle 2, back in IDLE at cycle 3.
